// File: rtl/bus_timer_if.sv
// bus_timer_if: single-port bus between the decoder (master) and the bus_timer device (slave).
// req_in/addr_in/we_in/wdata_in carry one request per asserted cycle.
// rdata_out returns registered read data one cycle later.
// irq_out is the timer interrupt level.
interface bus_timer_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic                    req_in;
    logic [AddressWidth-1:0] addr_in;
    logic                    we_in;
    logic [DataWidth-1:0]    wdata_in;
    logic [DataWidth-1:0]    rdata_out;
    logic                    irq_out;

    modport master (output req_in, addr_in, we_in, wdata_in, input rdata_out, irq_out);
    modport slave  (input req_in, addr_in, we_in, wdata_in, output rdata_out, irq_out);
endinterface

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 64-bit timer/compare peripheral with a prescaler and a level interrupt.
// clk_in   : clock; all state changes on its rising edge.
// reset_in : asynchronous active-low reset.
// bus      : slave side of bus_timer_if (request, address, write data, registered read data, irq).
module bus_timer #(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int PrescaleWidth = 8
) (
    input logic        clk_in,
    input logic        reset_in,
    bus_timer_if.slave bus
);
    localparam int PW = PrescaleWidth;

    logic                 en_q, en_d, irq_en_q, irq_en_d, pending_q, pending_d;
    logic [PW-1:0]        prescale_q, prescale_d, psc_q, psc_d;
    logic [63:0]          mtime_q, mtime_d, cmp_q, cmp_d;
    logic [31:0]          shadow_q, shadow_d;
    logic [DataWidth-1:0] rdata_q, rdata_d, rd_val;
    logic [2:0]           off;
    logic                 wr, rd, tick, set, clr;
    logic                 wr_ctrl, wr_lo, wr_hi, wr_clo, wr_chi;
    logic                 unused_bits;

    assign off     = bus.addr_in[4:2];
    assign wr      = bus.req_in & bus.we_in;
    assign rd      = bus.req_in & ~bus.we_in;
    assign wr_ctrl = wr && off == 3'd0;
    assign wr_lo   = wr && off == 3'd2;
    assign wr_hi   = wr && off == 3'd3;
    assign wr_clo  = wr && off == 3'd4;
    assign wr_chi  = wr && off == 3'd5;
    assign clr     = wr && off == 3'd1 && bus.wdata_in[0];
    assign tick    = en_q && psc_q == prescale_q;
    assign set     = en_q && mtime_q >= cmp_q;

    assign unused_bits = ^{bus.addr_in[AddressWidth-1:5], bus.addr_in[1:0],
                           bus.wdata_in[DataWidth-1:8+PW], bus.wdata_in[7:2]};

    always_comb begin
        case (off)
            3'd0:    rd_val = {{(DataWidth-8-PW){1'b0}}, prescale_q, 6'b0, irq_en_q, en_q};
            3'd1:    rd_val = {{(DataWidth-1){1'b0}}, pending_q};
            3'd2:    rd_val = mtime_q[31:0];
            3'd3:    rd_val = shadow_q;
            3'd4:    rd_val = cmp_q[31:0];
            3'd5:    rd_val = cmp_q[63:32];
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        en_d       = wr_ctrl ? bus.wdata_in[0] : en_q;
        irq_en_d   = wr_ctrl ? bus.wdata_in[1] : irq_en_q;
        prescale_d = wr_ctrl ? bus.wdata_in[8+PW-1:8] : prescale_q;
        psc_d      = (wr_ctrl || !en_q || tick) ? '0 : psc_q + PW'(1);
        // A software write to either half swallows a coincident tick entirely.
        mtime_d    = (wr_lo || wr_hi) ?
                     {wr_hi ? bus.wdata_in : mtime_q[63:32], wr_lo ? bus.wdata_in : mtime_q[31:0]} :
                     mtime_q + 64'(tick);
        cmp_d      = {wr_chi ? bus.wdata_in : cmp_q[63:32], wr_clo ? bus.wdata_in : cmp_q[31:0]};
        pending_d  = set | (pending_q & ~clr);
        // Latch the pre-tick HI alongside the LO read so LO-then-HI is coherent.
        shadow_d   = (rd && off == 3'd2) ? mtime_q[63:32] : shadow_q;
        rdata_d    = rd ? rd_val : '0;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            psc_q      <= '0;
            mtime_q    <= '0;
            cmp_q      <= '1;
            pending_q  <= 1'b0;
            shadow_q   <= '0;
            rdata_q    <= '0;
        end else begin
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
            mtime_q    <= mtime_d;
            cmp_q      <= cmp_d;
            pending_q  <= pending_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.rdata_out = rdata_q;
    assign bus.irq_out   = pending_q & irq_en_q;
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed self-checking bench for bus_timer.
// Drives the bus_timer_if master side and checks read data and irq against hand-computed values.
`timescale 1ns/1ps
module tb_bus_timer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] d;

    bus_timer_if #(.DataWidth(32), .AddressWidth(32)) bus ();

    bus_timer #(.DataWidth(32), .AddressWidth(32), .PrescaleWidth(8)) dut (
        .clk_in  (clk),
        .reset_in(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        bus.addr_in = a; bus.wdata_in = v; bus.we_in = 1'b1; bus.req_in = 1'b1;
        @(posedge clk); #1;
        bus.req_in = 1'b0; bus.we_in = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.addr_in = a; bus.we_in = 1'b0; bus.req_in = 1'b1;
        @(posedge clk); #1;
        bus.req_in = 1'b0;
        v = bus.rdata_out;
    endtask

    task automatic test_reset;
        logic [31:0] exp_r [6];
        logic [31:0] adr_r [6];
        wr(32'h14, 0); wr(32'h10, 0); wr(32'h0, 32'h3);
        @(posedge clk); #1;
        checks++; if (bus.irq_out !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%b exp=1", bus.irq_out); end
        bus.addr_in = 0; bus.we_in = 1'b0; bus.req_in = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.rdata_out !== 32'h3) begin errors++; $display("FAIL pre_reset_rdata got=%h exp=3", bus.rdata_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.rdata_out !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata_out); end
        checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", bus.irq_out); end
        bus.req_in = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        adr_r = '{32'h10, 32'h14, 32'h8, 32'hC, 32'h0, 32'h4};
        exp_r = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            rd(adr_r[i], d);
            checks++; if (d !== exp_r[i]) begin errors++; $display("FAIL reset_value off=%h got=%h exp=%h", adr_r[i], d, exp_r[i]); end
        end
    endtask

    task automatic test_prescale;
        wr(32'h0, 32'h0301);
        repeat (40) @(posedge clk);
        #1;
        rd(32'h8, d);
        checks++; if (d !== 32'd10) begin errors++; $display("FAIL prescale_mtime got=%0d exp=10", d); end
    endtask

    task automatic test_wrap_shadow;
        logic [31:0] exp_a [4];
        logic [31:0] exp_b [4];
        logic [31:0] adr [4];
        adr   = '{32'h8, 32'hC, 32'h8, 32'hC};
        exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h0};
        exp_b = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0};
        wr(32'h0, 0); wr(32'hC, 32'hFFFF_FFFF); wr(32'h8, 32'hFFFF_FFFE); wr(32'h0, 32'h1);
        for (int i = 0; i < 4; i++) begin
            rd(adr[i], d);
            checks++; if (d !== exp_a[i]) begin errors++; $display("FAIL wrap_a step=%0d got=%h exp=%h", i, d, exp_a[i]); end
        end
        wr(32'h0, 0); wr(32'hC, 32'hFFFF_FFFF); wr(32'h8, 32'hFFFF_FFFE); wr(32'h0, 32'h1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rd(adr[i], d);
            checks++; if (d !== exp_b[i]) begin errors++; $display("FAIL wrap_b step=%0d got=%h exp=%h", i, d, exp_b[i]); end
        end
    endtask

    task automatic test_compare_irq;
        wr(32'h0, 0); wr(32'h4, 1);
        rd(32'h4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL status_cleared got=%h exp=0", d); end
        wr(32'h8, 0); wr(32'hC, 0); wr(32'h14, 0); wr(32'h10, 32'h10);
        wr(32'h0, 32'h3);
        repeat (16) @(posedge clk);
        #1;
        checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", bus.irq_out); end
        @(posedge clk); #1;
        checks++; if (bus.irq_out !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", bus.irq_out); end
        wr(32'h4, 1);
        checks++; if (bus.irq_out !== 1'b1) begin errors++; $display("FAIL irq_clear_blocked got=%b exp=1", bus.irq_out); end
        rd(32'h4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL pending_held got=%h exp=1", d); end
        wr(32'h10, 32'hFFFF_FFFF); wr(32'h14, 32'hFFFF_FFFF);
        wr(32'h4, 1);
        checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL irq_cleared got=%b exp=0", bus.irq_out); end
        rd(32'h4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL pending_cleared got=%h exp=0", d); end
    endtask

    task automatic test_collision;
        wr(32'h8, 32'h100);
        rd(32'h8, d);
        checks++; if (d !== 32'h100) begin errors++; $display("FAIL collision got=%h exp=100", d); end
        rd(32'h18, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped6 got=%h exp=0", d); end
        wr(32'h1C, 32'hFFFF_FFFF);
        rd(32'h1C, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped7 got=%h exp=0", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_r [6];
        exp_r = '{32'h0502, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h55, 32'hAA};
        wr(32'h0, 32'h0502); wr(32'h8, 32'h1234_5678); wr(32'hC, 32'h9ABC_DEF0);
        wr(32'h10, 32'h55); wr(32'h14, 32'hAA);
        for (int i = 0; i < 6; i++) begin
            bus.addr_in = 32'hABCD_E000 | (i << 2); bus.we_in = 1'b0; bus.req_in = 1'b1;
            @(posedge clk); #1;
            checks++; if (bus.rdata_out !== exp_r[i]) begin errors++; $display("FAIL b2b off=%0d got=%h exp=%h", i, bus.rdata_out, exp_r[i]); end
        end
        bus.req_in = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.rdata_out !== 32'h0) begin errors++; $display("FAIL idle_rdata got=%h exp=0", bus.rdata_out); end
    endtask

    initial begin
        bus.req_in = 1'b0; bus.we_in = 1'b0; bus.addr_in = '0; bus.wdata_in = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset;
        test_prescale;
        test_wrap_shadow;
        test_compare_irq;
        test_collision;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped 64-bit timer/compare peripheral that sits on a single device port of the system bus, downstream of the bus's address decode. It accepts single-cycle read/write requests, returns read data one cycle later as the bus expects, and raises a level interrupt when the free-running 64-bit counter reaches a programmable 64-bit compare value. A programmable prescaler sets the tick rate.

## Interface
- DataWidth, 32, bus data width; only 32 is supported.
- AddressWidth, 32, bus address width; only addr_in[4:2] is decoded, all other bits are ignored.
- PrescaleWidth, 8, width of CTRL.PRESCALE and of the internal prescale counter.

Ports:
- clk_in  input  1  sole clock; all state changes on its rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- req_in  input  1  request strobe from the bus; one request per asserted cycle.
- addr_in  input  AddressWidth  byte address; register offset is addr_in[4:2].
- we_in  input  1  1 = write, 0 = read; qualified by req_in.
- wdata_in  input  DataWidth  write data; qualified by req_in & we_in.
- rdata_out  output  DataWidth  read data, registered.
- irq_out  output  1  interrupt level, equal to STATUS.PENDING & CTRL.IRQ_EN.

## Operation
- Register map (offset = addr_in[4:2]):
  - 0 CTRL (RW): bit0 EN, bit1 IRQ_EN, bits[8+PrescaleWidth-1:8] PRESCALE. Reset 0.
  - 1 STATUS (RW1C): bit0 PENDING. Reset 0.
  - 2 MTIME_LO (RW): mtime[31:0]. Reset 0.
  - 3 MTIME_HI (RW): a write sets mtime[63:32]; a read returns the shadow latched by the last MTIME_LO read.
  - 4 CMP_LO (RW), 5 CMP_HI (RW): cmp[31:0] and cmp[63:32]. Reset all ones.
  - 6, 7: reads return 0; writes are ignored.
  - Unused register bits read 0.
- Prescaler:
  - EN=0: the prescale counter is held at 0 and mtime is frozen.
  - EN=1: the counter increments each cycle. When it equals PRESCALE, it returns to 0 and a tick fires. Ticks occur every PRESCALE+1 cycles.
  - Any CTRL write clears the prescale counter.
- mtime increments by 1 per tick, modulo 2^64, so 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- A carry from the LO word into the HI word happens in the same cycle.
- Writes to mtime:
  - A MTIME_LO or MTIME_HI write replaces only that half.
  - A write in the same cycle as a tick takes precedence; that tick is lost, not deferred.
- Shadow read:
  - A MTIME_LO read latches mtime[63:32] into the shadow at the same edge that captures rdata_out.
  - Software reads LO then HI to get a coherent 64-bit value.
  - The shadow reset value is 0.
- Compare and PENDING:
  - set = EN & (mtime >= cmp), an unsigned 64-bit compare on current register values.
  - PENDING_next = set | (PENDING & ~clear), where clear = STATUS write with wdata_in[0]=1.
  - Set wins over clear. A clear is ineffective while the condition still holds.
- irq_out is driven purely from flops, with no combinational path from the inputs.

## Timing
- Reset (reset_in=0, asynchronous): every register takes its reset value; rdata_out=0 and irq_out=0 immediately.
- Write: takes effect at the rising edge where req_in & we_in is sampled; new values are visible from the next cycle.
- Read: rdata_out is valid exactly 1 cycle after the req_in & ~we_in edge. It returns the register value as it was before that edge.
- In any cycle following a non-read cycle, rdata_out=0.
- Back-to-back requests on consecutive cycles are fully supported. There is no backpressure; every request completes.
- Read of MTIME_LO during a tick: returns the pre-increment value, and the shadow latches the matching pre-increment HI.
- PENDING rises 1 cycle after the edge at which mtime >= cmp first holds. irq_out follows in the same cycle as PENDING.
- Setting EN=0 freezes mtime but leaves PENDING unchanged.
- Reset asserted mid-operation: all state is discarded; no partially completed write or read survives.

## Test plan
- Reset: hold reset_in=0 mid-traffic, then release. Required: rdata_out=0, irq_out=0; CMP_LO/HI read 0xFFFF_FFFF; MTIME_LO/HI read 0.
- Prescale: set PRESCALE=3, EN=1, then idle 40 cycles and read MTIME_LO. Required: value 10 (±1 for the CTRL-write cycle alignment, checked exactly against the model).
- Wrap and shadow: write MTIME_HI=0xFFFF_FFFF and MTIME_LO=0xFFFF_FFFE, with EN=1 and PRESCALE=0. Read LO and HI until wrap. Required: the 64-bit value progresses …FFFE → …FFFF → 0x0000_0000_0000_0000, and the HI shadow always matches its LO.
- Compare/IRQ: set CMP=0x0000_0000_0000_0010 with IRQ_EN=1, EN=1, PRESCALE=0, and mtime starting at 0. Required: irq_out rises 1 cycle after mtime reaches 0x10. A STATUS write of 1 while mtime ≥ cmp leaves PENDING=1. Then set CMP to all ones and write STATUS=1. Required: PENDING=0 and irq_out=0 next cycle.
- Collision: write MTIME_LO=0x100 on the exact tick cycle. Required: the next read returns 0x100, not 0x101, and the read-of-unmapped offset 6 returns 0.
- Back-to-back: issue reads of offsets 0,1,2,3,4,5 on consecutive cycles. Required: each rdata_out appears exactly 1 cycle later, in order, with correct values.
